acc_drain: RTL
==============

# acc_drain

Output drain stage for the 64-lane MAC array. On a single-cycle `snap` request it captures all 64 accumulator outputs (`oC` of the array) into a shadow bank in one cycle, so the array keeps accumulating undisturbed. It then streams the captured values out one lane per cycle, lane 0 first, over a valid/ready handshake to the writeback path.

## Interface
Parameters:
- `LANES`, 64, number of array lanes captured and streamed; the lane index width is clog2(LANES).

Ports:
- `clk`  input  1  clock; all state is updated on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `snap`  input  1  capture request, single-cycle pulse.
- `iC`  input  [2*`MAC_BW-1:0] [LANES-1:0]  accumulator values from the array.
- `oValid`  output  1  `oData` holds a valid lane.
- `iReady`  input  1  consumer accepts the current lane.
- `oData`  output  2*`MAC_BW  value for the current lane.
- `oLane`  output  clog2(LANES)  index of the current lane.
- `oLast`  output  1  current lane is LANES-1.
- `busy`  output  1  a stream is in progress.
- `done`  output  1  one-cycle pulse after the last lane is accepted.
- `ovf`  output  1  sticky flag: a `snap` arrived while the block was busy.

## Operation
- FSM states are IDLE and STREAM. Reset puts the FSM in IDLE.
- IDLE:
  - With `snap`=1, all LANES values of `iC` are latched into the shadow bank, lane counter goes to 0, `ovf` is cleared, and the FSM moves to STREAM.
  - With `snap`=0, nothing changes.
- STREAM:
  - `oValid`=1, `busy`=1, `oLane`=counter, and `oData`=shadow[counter] after optional saturation.
  - A handshake is `oValid && iReady`. On a handshake the counter increments.
  - A handshake with counter = LANES-1 moves the FSM to IDLE and sets `done` for the next cycle.
  - With `iReady`=0, `oData`, `oLane` and `oLast` hold stable. `oValid` never drops without a handshake.
- A `snap` in STREAM, including the cycle of the final handshake, is ignored and sets `ovf`=1. `ovf` stays set until the next accepted `snap`.
- The shadow bank is written only on an accepted `snap`. Changes on `iC` during STREAM have no effect on output.
- Asserting `rst_n`=0 mid-stream aborts immediately. Resume is not supported; the data is discarded.

## Timing
- Reset values: `oValid`=0, `oData`=0, `oLane`=0, `oLast`=0, `busy`=0, `done`=0, `ovf`=0. The shadow bank resets to 0.
- Latency: `snap` sampled at edge N gives `oValid`=1 with lane 0 from edge N (visible in cycle N+1).
- Throughput is one lane per cycle when `iReady` is held at 1, so a full drain takes LANES cycles.
- The final handshake at edge M gives `busy`=0, `oValid`=0 and `done`=1 in cycle M+1.
- The earliest new `snap` is accepted at edge M+1.
- `oData`, `oLane` and `oLast` are registered outputs. There is no combinational path from `iReady` to any output.

## Configuration
- `DRAIN_SAT_EN` defined:
  - `oData` is the shadow value clamped to the signed `MAC_BW range [-2^(`MAC_BW-1), 2^(`MAC_BW-1)-1], sign-extended to 2*`MAC_BW.
  - The clamp is applied on the output side; the shadow bank keeps full precision.
- `DRAIN_SAT_EN` undefined: `oData` is the shadow value unmodified at full 2*`MAC_BW width.

## Test plan
1. Capture and stream: load `iC[i]`=i+1, pulse `snap`, hold `iReady`=1.
   - 64 consecutive beats with `oLane`=0..63 and `oData`=1..64.
   - `oLast` on beat 63 only, then `done` for 1 cycle and `busy`=0.
2. Backpressure: during a stream, drop `iReady` for 5 cycles at lane 10.
   - `oValid`=1 throughout, and `oLane`=10 and `oData` hold for all 5 cycles.
   - After release, the stream resumes at lane 11 with no lane lost or duplicated.
3. Capture isolation: after `snap`, change every `iC` value to 0xDEAD.
   - All streamed values equal the values present at the `snap` edge.
4. Overrun: pulse `snap` at lane 30, then again in the cycle of the lane-63 handshake.
   - Both pulses are ignored, `ovf`=1, and the stream completes normally.
   - A later `snap` starts a new stream and clears `ovf`.
5. Reset mid-stream: drop `rst_n` at lane 20.
   - All outputs are 0 immediately.
   - After release the block stays IDLE until a new `snap`.
6. Saturation (`DRAIN_SAT_EN`, `MAC_BW`=8): set `iC[0]`=300, `iC[1]`=-300, `iC[2]`=-5.
   - With the macro, `oData`=127, -128, -5.
   - Without the macro, `oData`=300, -300, -5.

Source files
------------

// File: rtl/acc_drain_if.sv
// Writeback stream interface of the accumulator drain stage.
// The master (acc_drain) presents one lane per beat; the slave accepts it with iReady.
`ifndef MAC_BW
`define MAC_BW 8
`endif

interface acc_drain_if #(
  parameter int DW = 2 * `MAC_BW,
  parameter int LW = 6
);
  logic          oValid;
  logic          iReady;
  logic [DW-1:0] oData;
  logic [LW-1:0] oLane;
  logic          oLast;

  modport master (output oValid, oData, oLane, oLast, input iReady);
  modport slave  (input oValid, oData, oLane, oLast, output iReady);
endinterface

// File: rtl/acc_drain.sv
// Shadow-captures all MAC array accumulators on snap and streams them out lane 0 first.
// Optional feature macro: DRAIN_SAT_EN clamps oData to the signed MAC_BW range.
`ifndef MAC_BW
`define MAC_BW 8
`endif

module acc_drain #(
  parameter int LANES = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                snap,
  input  logic [LANES-1:0][2*`MAC_BW-1:0]     iC,
  acc_drain_if.master                         wb,
  output logic                                busy,
  output logic                                done,
  output logic                                ovf
);

  localparam int DW = 2 * `MAC_BW;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t          state_q;
  logic [DW-1:0]   shadow_q [LANES];
  logic [LW-1:0]   lane_q;
  logic [LW-1:0]   lane_d;
  logic [DW-1:0]   data_q;
  logic            valid_q;
  logic            last_q;
  logic            busy_q;
  logic            done_q;
  logic            ovf_q;

  // Clamp is on the output side only, so the shadow bank keeps full precision.
  function automatic logic [DW-1:0] sat_f(input logic [DW-1:0] v);
`ifdef DRAIN_SAT_EN
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    hi = {{(`MAC_BW + 1){1'b0}}, {(`MAC_BW - 1){1'b1}}};
    lo = ~hi;
    if ($signed(v) > $signed(hi)) begin
      return hi;
    end else if ($signed(v) < $signed(lo)) begin
      return lo;
    end else begin
      return v;
    end
`else
    return v;
`endif
  endfunction

  assign lane_d = lane_q + LW'(1);

  // Drain FSM with all outputs registered; iReady only affects next-state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= {LW{1'b0}};
      data_q  <= {DW{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        shadow_q[i] <= {DW{1'b0}};
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (snap) begin
            for (int i = 0; i < LANES; i++) begin
              shadow_q[i] <= iC[i];
            end
            lane_q  <= {LW{1'b0}};
            data_q  <= sat_f(iC[0]);
            last_q  <= (LANES == 1);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            ovf_q   <= 1'b0;
            state_q <= STREAM;
          end else begin
            state_q <= IDLE;
          end
        end
        STREAM: begin
          // A snap while streaming is dropped, including on the final handshake.
          if (snap) begin
            ovf_q <= 1'b1;
          end else begin
            ovf_q <= ovf_q;
          end
          if (wb.iReady) begin
            if (lane_q == LAST_LANE) begin
              state_q <= IDLE;
              lane_q  <= {LW{1'b0}};
              data_q  <= {DW{1'b0}};
              last_q  <= 1'b0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              lane_q <= lane_d;
              data_q <= sat_f(shadow_q[lane_d]);
              last_q <= (lane_d == LAST_LANE);
            end
          end else begin
            state_q <= STREAM;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wb.oValid = valid_q;
  assign wb.oData  = data_q;
  assign wb.oLane  = lane_q;
  assign wb.oLast  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule
